// File: rtl/density_accumulator.sv
// density_accumulator
//   Sums per-neighbour binary16 kernel contributions into one binary16 density
//   per particle. Inputs are queued in a small FIFO; a single-issue FSM feeds
//   one binary16 adder, since each add depends on the previous sum.
//   Optional feature macro: DENSITY_MASS_SCALE_EN. When defined, each finished
//   sum is multiplied by MASS before it is emitted.
//
// Ports (density_accumulator)
//   clk_in            sole clock
//   rst_n             asynchronous active-low reset
//   kernel_in         binary16 kernel contribution (non-negative)
//   kernel_valid_in   kernel_in / idx_in / last_in valid this cycle
//   idx_in            particle index of the contribution
//   last_in           final neighbour of the current particle
//   in_ready          FIFO not full (from the registered count)
//   density_out       binary16 density result
//   density_idx_out   particle index of density_out
//   density_valid_out one-cycle result strobe
//   overflow          sticky: data presented while in_ready was low
//   busy              FIFO non-empty or FSM not idle
//
// Ports (binary16_adder / binary16_multi), one cycle latency
//   clk, rst (async, active-high), a, b, data_valid_in, result, data_valid_out

module binary16_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        data_valid_in,
    output logic [15:0] result,
    output logic        data_valid_out
);
    // Operands are treated as non-negative (sign bits ignored); the fraction is
    // truncated after alignment.
    logic [4:0]  w_ea, w_eb, w_big_e, w_small_e, w_diff;
    logic [10:0] w_ma, w_mb, w_big_m, w_small_m, w_shifted;
    logic [11:0] w_sum;
    logic [5:0]  w_exp;
    logic [9:0]  w_frac;
    logic [15:0] w_res;
    logic        w_unused_sign;

    assign w_unused_sign = a[15] ^ b[15];

    always_comb begin
        // Subnormals use an effective exponent of 1 with no hidden bit.
        w_ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
        w_eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
        w_ma = {|a[14:10], a[9:0]};
        w_mb = {|b[14:10], b[9:0]};
        if (w_eb > w_ea) begin
            w_big_e = w_eb; w_big_m = w_mb; w_small_e = w_ea; w_small_m = w_ma;
        end else begin
            w_big_e = w_ea; w_big_m = w_ma; w_small_e = w_eb; w_small_m = w_mb;
        end
        w_diff    = w_big_e - w_small_e;
        w_shifted = (w_diff > 5'd11) ? '0 : (w_small_m >> w_diff);
        w_sum     = {1'b0, w_big_m} + {1'b0, w_shifted};
        if (w_sum[11]) begin
            w_exp  = {1'b0, w_big_e} + 6'd1;
            w_frac = w_sum[10:1];
        end else begin
            // No hidden bit means both inputs were subnormal: stay subnormal.
            w_exp  = w_sum[10] ? {1'b0, w_big_e} : 6'd0;
            w_frac = w_sum[9:0];
        end
        if (w_exp >= 6'd31) w_res = 16'h7C00;
        else                w_res = {1'b0, w_exp[4:0], w_frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result         <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= data_valid_in;
            if (data_valid_in) result <= w_res;
        end
    end
endmodule

module binary16_multi (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        data_valid_in,
    output logic [15:0] result,
    output logic        data_valid_out
);
    // Subnormal operands and results flush to zero; the fraction is truncated.
    logic [21:0]       w_prod;
    logic signed [7:0] w_exp;
    logic [9:0]        w_frac;
    logic              w_sign;
    logic [15:0]       w_res;
    logic              w_unused_low;

    assign w_prod       = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    assign w_unused_low = ^w_prod[9:0];

    always_comb begin
        w_sign = a[15] ^ b[15];
        w_exp  = 8'(a[14:10]) + 8'(b[14:10]) - 8'sd15 + 8'(w_prod[21]);
        w_frac = w_prod[21] ? w_prod[20:11] : w_prod[19:10];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0 || w_exp <= 8'sd0)
            w_res = {w_sign, 15'd0};
        else if (w_exp >= 8'sd31)
            w_res = {w_sign, 15'h7C00};
        else
            w_res = {w_sign, w_exp[4:0], w_frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result         <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= data_valid_in;
            if (data_valid_in) result <= w_res;
        end
    end
endmodule

module density_accumulator #(
    parameter int          PARTICLE_COUNTER_SIZE = 2,
    parameter int          FIFO_DEPTH            = 4,
    parameter logic [15:0] MASS                  = 16'h3C00
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic [15:0]                      kernel_in,
    input  logic                             kernel_valid_in,
    input  logic [PARTICLE_COUNTER_SIZE-1:0] idx_in,
    input  logic                             last_in,
    output logic                             in_ready,
    output logic [15:0]                      density_out,
    output logic [PARTICLE_COUNTER_SIZE-1:0] density_idx_out,
    output logic                             density_valid_out,
    output logic                             overflow,
    output logic                             busy
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 17 + PARTICLE_COUNTER_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SCALE, S_EMIT} state_t;
    state_t r_state, w_next_state;

    logic [ENTRY_W-1:0]               r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                 r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]                 r_count;
    logic                             w_push, w_pop, w_empty;
    logic [ENTRY_W-1:0]               w_head;
    logic [15:0]                      r_acc;
    logic [PARTICLE_COUNTER_SIZE-1:0] r_cur_idx;
    logic                             r_cur_last;
    logic [15:0]                      r_density_out;
    logic [PARTICLE_COUNTER_SIZE-1:0] r_density_idx;
    logic                             r_density_valid, r_overflow;
    logic [15:0]                      w_add_result;
    logic                             w_add_valid_out;
    logic                             w_sub_rst;

    assign w_sub_rst = ~rst_n;
    assign in_ready  = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = kernel_valid_in && in_ready;
    assign w_pop     = (r_state == S_ISSUE);
    assign w_head    = r_mem[r_rd_ptr];

    assign density_out       = r_density_out;
    assign density_idx_out   = r_density_idx;
    assign density_valid_out = r_density_valid;
    assign overflow          = r_overflow;
    assign busy              = !w_empty || (r_state != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= {last_in, idx_in, kernel_in};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (kernel_valid_in && !in_ready) r_overflow <= 1'b1;
        end
    end

    binary16_adder u_add (
        .clk            (clk_in),
        .rst            (w_sub_rst),
        .a              (r_acc),
        .b              (w_head[15:0]),
        .data_valid_in  (w_pop),
        .result         (w_add_result),
        .data_valid_out (w_add_valid_out)
    );

`ifdef DENSITY_MASS_SCALE_EN
    logic [15:0] w_mul_result;
    logic        w_mul_valid_in, w_mul_valid_out, r_mul_pending;

    // The multiplier is pulsed only on the first SCALE cycle.
    assign w_mul_valid_in = (r_state == S_SCALE) && !r_mul_pending;

    binary16_multi u_mul (
        .clk            (clk_in),
        .rst            (w_sub_rst),
        .a              (r_acc),
        .b              (MASS),
        .data_valid_in  (w_mul_valid_in),
        .result         (w_mul_result),
        .data_valid_out (w_mul_valid_out)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)               r_mul_pending <= 1'b0;
        else if (w_mul_valid_out) r_mul_pending <= 1'b0;
        else if (w_mul_valid_in)  r_mul_pending <= 1'b1;
    end
`else
    logic w_unused_mass;
    assign w_unused_mass = ^MASS;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_add_valid_out) begin
                    if (r_cur_last) begin
`ifdef DENSITY_MASS_SCALE_EN
                        w_next_state = S_SCALE;
`else
                        w_next_state = S_EMIT;
`endif
                    end else begin
                        w_next_state = w_empty ? S_IDLE : S_ISSUE;
                    end
                end
            end
`ifdef DENSITY_MASS_SCALE_EN
            S_SCALE: if (w_mul_valid_out) w_next_state = S_EMIT;
`endif
            // Going straight to ISSUE lets a queued group start the next cycle.
            S_EMIT:  w_next_state = w_empty ? S_IDLE : S_ISSUE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_acc           <= '0;
            r_cur_idx       <= '0;
            r_cur_last      <= 1'b0;
            r_density_out   <= '0;
            r_density_idx   <= '0;
            r_density_valid <= 1'b0;
        end else begin
            r_density_valid <= 1'b0;
            case (r_state)
                S_ISSUE: begin
                    r_cur_idx  <= w_head[16 +: PARTICLE_COUNTER_SIZE];
                    r_cur_last <= w_head[ENTRY_W-1];
                end
                S_WAIT: if (w_add_valid_out) r_acc <= w_add_result;
`ifdef DENSITY_MASS_SCALE_EN
                S_SCALE: if (w_mul_valid_out) r_acc <= w_mul_result;
`endif
                S_EMIT: begin
                    r_density_out   <= r_acc;
                    r_density_idx   <= r_cur_idx;
                    r_density_valid <= 1'b1;
                    r_acc           <= '0;
                    r_cur_idx       <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_density_accumulator.sv
// Directed bench for density_accumulator. A second instance with MASS = 2.0
// shares all inputs; its expected results depend on DENSITY_MASS_SCALE_EN.
module tb_density_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] kernel_in;
    logic        kernel_valid_in;
    logic [1:0]  idx_in;
    logic        last_in;

    logic        in_ready, density_valid_out, overflow, busy;
    logic [15:0] density_out;
    logic [1:0]  density_idx_out;
    logic        d2_in_ready, d2_valid, d2_overflow, d2_busy;
    logic [15:0] d2_out;
    logic [1:0]  d2_idx;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef DENSITY_MASS_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    density_accumulator #(.PARTICLE_COUNTER_SIZE(2), .FIFO_DEPTH(4), .MASS(16'h3C00)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .kernel_in(kernel_in), .kernel_valid_in(kernel_valid_in),
        .idx_in(idx_in), .last_in(last_in), .in_ready(in_ready), .density_out(density_out),
        .density_idx_out(density_idx_out), .density_valid_out(density_valid_out),
        .overflow(overflow), .busy(busy)
    );

    density_accumulator #(.PARTICLE_COUNTER_SIZE(2), .FIFO_DEPTH(4), .MASS(16'h4000)) u_dut2 (
        .clk_in(clk), .rst_n(rst_n), .kernel_in(kernel_in), .kernel_valid_in(kernel_valid_in),
        .idx_in(idx_in), .last_in(last_in), .in_ready(d2_in_ready), .density_out(d2_out),
        .density_idx_out(d2_idx), .density_valid_out(d2_valid),
        .overflow(d2_overflow), .busy(d2_busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one item for exactly one rising edge.
    task automatic push(input logic [15:0] k, input logic [1:0] idx, input logic last);
        kernel_in = k; idx_in = idx; last_in = last; kernel_valid_in = 1'b1;
        @(negedge clk);
        kernel_valid_in = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp_d,
                               input logic [1:0] exp_idx, input logic [15:0] exp_d2,
                               input bit chk_idle);
        int unsigned n = 0;
        while (density_valid_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_strobe"}, 16'(density_valid_out), 16'h1);
        check({tag, "_data"}, density_out, exp_d);
        check({tag, "_idx"}, 16'(density_idx_out), 16'(exp_idx));
        check({tag, "_d2_strobe"}, 16'(d2_valid), 16'h1);
        check({tag, "_d2_data"}, d2_out, exp_d2);
        @(negedge clk);
        check({tag, "_width"}, 16'(density_valid_out), 16'h0);
        if (chk_idle) check({tag, "_busy"}, 16'(busy), 16'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
        check({tag, "_out"}, density_out, 16'h0000);
        check({tag, "_idx"}, 16'(density_idx_out), 16'h0);
        check({tag, "_valid"}, 16'(density_valid_out), 16'h0);
        check({tag, "_overflow"}, 16'(overflow), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_d2_flags"}, {13'd0, d2_in_ready, d2_overflow, d2_busy}, 16'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; kernel_in = '0; kernel_valid_in = 1'b0; idx_in = '0; last_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1+1+1 = 3.0 (0x4200); with MASS 2.0 scaling 6.0 (0x4600).
        push(16'h3C00, 2'd2, 1'b0);
        push(16'h3C00, 2'd2, 1'b0);
        push(16'h3C00, 2'd2, 1'b1);
        wait_result("sum3", 16'h4200, 2'd2, SCALE_ON ? 16'h4600 : 16'h4200, 1'b1);

        // Back-to-back groups: 0.5+0.25 = 0.75, then 1.0 alone.
        push(16'h3800, 2'd1, 1'b0);
        push(16'h3400, 2'd1, 1'b1);
        push(16'h3C00, 2'd3, 1'b1);
        wait_result("grp1", 16'h3A00, 2'd1, SCALE_ON ? 16'h3E00 : 16'h3A00, 1'b0);
        wait_result("grp2", 16'h3C00, 2'd3, SCALE_ON ? 16'h4000 : 16'h3C00, 1'b1);
        repeat (3) @(negedge clk);

        // Hold valid for 8 edges (last=0). Edge 6 sees a full FIFO and is
        // dropped, so 7 of the 8 ones are summed.
        for (int i = 0; i < 8; i++) begin
            if (i == 0) check("ovf_ready_start", 16'(in_ready), 16'h1);
            if (i == 6) check("ovf_ready_full", 16'(in_ready), 16'h0);
            if (i == 7) check("ovf_ready_back", 16'(in_ready), 16'h1);
            kernel_in = 16'h3C00; idx_in = 2'd0; last_in = 1'b0; kernel_valid_in = 1'b1;
            @(negedge clk);
        end
        kernel_valid_in = 1'b0;
        check("ovf_sticky", 16'(overflow), 16'h1);
        repeat (20) @(negedge clk);
        check("ovf_drained_busy", 16'(busy), 16'h0);
        push(16'h0000, 2'd0, 1'b1);
        wait_result("ovf_sum", 16'h4700, 2'd0, SCALE_ON ? 16'h4B00 : 16'h4700, 1'b1);
        check("ovf_still_set", {15'd0, overflow}, 16'h1);
        check("ovf_d2_set", {15'd0, d2_overflow}, 16'h1);

        // Reset while the first item is in WAIT with two more queued.
        push(16'h3C00, 2'd1, 1'b0);
        push(16'h3C00, 2'd1, 1'b0);
        push(16'h3C00, 2'd1, 1'b0);
        check("mid_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(16'h3C00, 2'd2, 1'b1);
        wait_result("post_reset", 16'h3C00, 2'd2, SCALE_ON ? 16'h4000 : 16'h3C00, 1'b1);

        // Zero contribution.
        push(16'h0000, 2'd1, 1'b1);
        wait_result("zero", 16'h0000, 2'd1, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
